// File: rtl/id_control_if.sv
// id_control_if: IF/ID-side instruction inputs and ID/EX-side control outputs of the decode controller.
interface id_control_if;
    logic        inst_valid;
    logic [15:0] inst;
    logic        flush;
    logic        stall;
    logic [3:0]  alu_operation;
    logic [3:0]  shamt;
    logic [2:0]  rdst;
    logic [2:0]  rsrc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  sp_op;
    logic [2:0]  branch_type;
    logic        flag_restore;
    logic [15:0] imm;
    logic        imm_valid;

    modport master (
        output inst_valid, inst, flush,
        input  stall, alu_operation, shamt, rdst, rsrc, reg_write, mem_read, mem_write,
               sp_op, branch_type, flag_restore, imm, imm_valid
    );

    modport slave (
        input  inst_valid, inst, flush,
        output stall, alu_operation, shamt, rdst, rsrc, reg_write, mem_read, mem_write,
               sp_op, branch_type, flag_restore, imm, imm_valid
    );
endinterface

// File: rtl/id_control_unit.sv
// id_control_unit: decode-stage controller producing registered ALU code and control strobes,
// sequencing two-word LDM and the CALL/RET/RTI stack operations while stalling fetch.
module id_control_unit #(
    parameter int RTI_POPS  = 2,
    parameter int RET_STALL = 1
) (
    input logic         clk,
    input logic         rst,
    id_control_if.slave bus
);
    localparam logic [2:0] S_DECODE    = 3'd0;
    localparam logic [2:0] S_LDM_IMM   = 3'd1;
    localparam logic [2:0] S_CALL_PUSH = 3'd2;
    localparam logic [2:0] S_POP_PC    = 3'd3;
    localparam logic [2:0] S_POP_FLAGS = 3'd4;
    localparam logic [2:0] S_BUBBLE    = 3'd5;
    localparam logic [3:0] ALU_NOP = 4'b0011;
    localparam logic [3:0] ALU_MOV = 4'b0111;
    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam int CW = RET_STALL > 2 ? $clog2(RET_STALL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RET_STALL > 0 ? RET_STALL - 1 : 0);
    localparam logic [2:0] AFTER_POP = RET_STALL > 0 ? S_BUBBLE : S_DECODE;

    logic [2:0]    state_q, state_d;
    logic          rti_q, rti_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    alu_q, alu_d, shamt_q, shamt_d;
    logic [2:0]    rdst_q, rdst_d, rsrc_q, rsrc_d, branch_q, branch_d;
    logic          reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [1:0]    sp_op_q, sp_op_d;
    logic          flag_q, flag_d, imm_valid_q, imm_valid_d;
    logic [15:0]   imm_q, imm_d;
    logic [4:0]    op;

    assign op = bus.inst[15:11];

    always_comb begin
        state_d     = state_q;
        rti_d       = rti_q;
        cnt_d       = cnt_q;
        alu_d       = ALU_NOP;
        shamt_d     = shamt_q;
        rdst_d      = rdst_q;
        rsrc_d      = rsrc_q;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        sp_op_d     = 2'b00;
        branch_d    = 3'b000;
        flag_d      = 1'b0;
        imm_d       = imm_q;
        imm_valid_d = 1'b0;
        if (bus.flush) begin
            state_d = S_DECODE;
        end else begin
            case (state_q)
                S_DECODE: if (bus.inst_valid) begin
                    rdst_d  = bus.inst[10:8];
                    rsrc_d  = bus.inst[7:5];
                    shamt_d = bus.inst[3:0];
                    if (!op[4]) begin
                        alu_d       = (op[3:0] == 4'd0 || op[3:0] >= 4'd14) ? ALU_NOP : op[3:0];
                        reg_write_d = op[3:0] == 4'd2 || (op[3:0] >= 4'd4 && op[3:0] <= 4'd13);
                    end else begin
                        case (op[3:0])
                            4'd0: begin mem_write_d = 1'b1; sp_op_d = 2'b01; alu_d = ALU_MOV; end
                            4'd1: begin mem_read_d = 1'b1; sp_op_d = 2'b10; reg_write_d = 1'b1; end
                            4'd2: state_d = S_LDM_IMM;
                            4'd3: begin mem_read_d = 1'b1; reg_write_d = 1'b1; alu_d = ALU_ADD; end
                            4'd4: begin mem_write_d = 1'b1; alu_d = ALU_ADD; end
                            4'd8, 4'd9, 4'd10, 4'd11: branch_d = 3'(op[1:0]) + 3'd1;
                            4'd12: state_d = S_CALL_PUSH;
                            4'd13: begin state_d = S_POP_PC; rti_d = 1'b0; end
                            4'd14: begin state_d = S_POP_PC; rti_d = 1'b1; end
                            default: ;
                        endcase
                    end
                end
                S_LDM_IMM: if (bus.inst_valid) begin
                    imm_d       = bus.inst;
                    imm_valid_d = 1'b1;
                    reg_write_d = 1'b1;
                    alu_d       = ALU_MOV;
                    state_d     = S_DECODE;
                end
                S_CALL_PUSH: begin
                    mem_write_d = 1'b1;
                    sp_op_d     = 2'b01;
                    branch_d    = 3'b100;
                    state_d     = S_DECODE;
                end
                S_POP_PC: begin
                    mem_read_d = 1'b1;
                    sp_op_d    = 2'b10;
                    branch_d   = rti_q ? 3'b110 : 3'b101;
                    state_d    = (rti_q && RTI_POPS > 1) ? S_POP_FLAGS : AFTER_POP;
                    cnt_d      = CNT_LOAD;
                end
                S_POP_FLAGS: begin
                    mem_read_d = 1'b1;
                    sp_op_d    = 2'b10;
                    flag_d     = 1'b1;
                    state_d    = AFTER_POP;
                    cnt_d      = CNT_LOAD;
                end
                S_BUBBLE: begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = cnt_q == '0 ? S_DECODE : S_BUBBLE;
                end
                default: state_d = S_DECODE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DECODE;
            rti_q       <= 1'b0;
            cnt_q       <= '0;
            alu_q       <= ALU_NOP;
            shamt_q     <= '0;
            rdst_q      <= '0;
            rsrc_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            sp_op_q     <= '0;
            branch_q    <= '0;
            flag_q      <= 1'b0;
            imm_q       <= '0;
            imm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rti_q       <= rti_d;
            cnt_q       <= cnt_d;
            alu_q       <= alu_d;
            shamt_q     <= shamt_d;
            rdst_q      <= rdst_d;
            rsrc_q      <= rsrc_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            sp_op_q     <= sp_op_d;
            branch_q    <= branch_d;
            flag_q      <= flag_d;
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
        end
    end

    assign bus.stall         = state_q inside {S_CALL_PUSH, S_POP_PC, S_POP_FLAGS, S_BUBBLE};
    assign bus.alu_operation = alu_q;
    assign bus.shamt         = shamt_q;
    assign bus.rdst          = rdst_q;
    assign bus.rsrc          = rsrc_q;
    assign bus.reg_write     = reg_write_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.sp_op         = sp_op_q;
    assign bus.branch_type   = branch_q;
    assign bus.flag_restore  = flag_q;
    assign bus.imm           = imm_q;
    assign bus.imm_valid     = imm_valid_q;
endmodule

// File: doc/id_control_unit.md
Name: id_control_unit

Overview:
- Decode-stage controller feeding the ALU and the rest of the ID/EX boundary.
- Turns each 16-bit instruction word into a registered 4-bit alu_operation code plus control strobes.
- Sequences the multi-cycle instructions (two-word LDM, CALL, RET, RTI) with a small FSM and stalls fetch while doing so.
- Sits between the IF/ID buffer and the ID/EX buffer.

Parameters:
- RTI_POPS, 2, number of stack pops RTI performs (PC, then flags).
- RET_STALL, 1, extra bubble cycles inserted after RET/RTI pops before fetch resumes.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- inst_valid  in  1  inst holds a fetched word this cycle
- inst  in  16  instruction/immediate word: opcode [15:11], rdst [10:8], rsrc [7:5], shamt [3:0]
- flush  in  1  branch resolved taken in EX; kill current decode
- stall  out  1  hold PC and IF/ID (combinational from state)
- alu_operation  out  4  ALU code, registered
- shamt  out  4  registered inst[3:0]
- rdst  out  3  registered destination register
- rsrc  out  3  registered source register
- reg_write  out  1  writeback enable
- mem_read  out  1  data-memory read
- mem_write  out  1  data-memory write
- sp_op  out  2  00 none, 01 push (SP-1 after), 10 pop (SP+1 before)
- branch_type  out  3  000 none, 001 JZ, 010 JN, 011 JC, 100 JMP/CALL, 101 RET, 110 RTI
- flag_restore  out  1  this pop restores the flag register
- imm  out  16  immediate for LDM
- imm_valid  out  1  imm is meaningful this cycle

Behaviour:
- Reset (rst=1 at edge): state=DECODE; every output 0, except alu_operation=4'b0011 (NOP).
- Outputs are registered: instruction accepted at edge N, controls visible after edge N+1.
- An instruction is accepted when inst_valid=1, state=DECODE and flush=0.
- inst_valid=0 in DECODE emits a bubble: alu_operation=NOP, all strobes 0.
- opcode[4]=0, ALU class: alu_operation=opcode[3:0]. reg_write=1 for codes 0010 and 0100..1101, 0 otherwise.
- ALU class exceptions: OUT=0001 (reg_write=0), NOP=0011. Undefined codes 0000, 1110 and 1111 decode as NOP.
- Memory/branch class, opcode[4]=1:
  - 10000 PUSH: mem_write, sp_op=01, alu=MOV (0111).
  - 10001 POP: mem_read, sp_op=10, reg_write.
  - 10010 LDM: two-word.
  - 10011 LDD: mem_read, reg_write, alu=ADD (address calc).
  - 10100 STD: mem_write, alu=ADD.
  - 11000/11001/11010 JZ/JN/JC, 11011 JMP, 11100 CALL, 11101 RET, 11110 RTI.
  - Any other opcode: NOP.
- FSM states: DECODE, LDM_IMM, CALL_PUSH, POP_PC, POP_FLAGS, BUBBLE.
  - LDM in DECODE -> LDM_IMM, stall=0. The next valid word is captured into imm with imm_valid=1, reg_write=1, alu=MOV. Then -> DECODE. Not decoded as an instruction.
  - CALL -> CALL_PUSH, stall=1. Emits mem_write, sp_op=01, branch_type=100. Then -> DECODE.
  - RET -> POP_PC, stall=1. Emits mem_read, sp_op=10, branch_type=101. Then -> BUBBLE for RET_STALL cycles, then DECODE.
  - RTI -> POP_PC (branch_type=110) -> POP_FLAGS (mem_read, sp_op=10, flag_restore=1) -> BUBBLE -> DECODE.
  - stall=1 in CALL_PUSH, POP_PC, POP_FLAGS and BUBBLE.
- Conditional jumps: branch_type set, alu=NOP, no writes.
- flush=1 has priority over everything except rst:
  - next registered outputs are a bubble; state forced to DECODE.
  - flush during LDM_IMM drops the immediate.
  - flush during CALL_PUSH, POP_PC or POP_FLAGS: EX issued the redirect, so the pending stack op is abandoned.
- inst_valid=0 while in LDM_IMM: stay in LDM_IMM emitting bubbles, with no timeout.
- rst mid-sequence: immediate return to DECODE; no partial strobes issued.
- Never two stack ops in one cycle; sp_op=11 never driven.

Test Plan:
- Reset then ADD (inst=16'h4000|rdst=2|rsrc=3) -> one cycle later alu_operation=1000, rdst=2, rsrc=3, reg_write=1, stall=0.
- SHL opcode 01100, shamt=5 -> alu_operation=1100, shamt=5, reg_write=1. Opcode 01111 -> NOP, reg_write=0.
- LDM then word 16'hBEEF -> cycle 1 bubble; cycle 2 imm=BEEF, imm_valid=1, alu=0111, reg_write=1. Idle (inst_valid=0) between the words keeps state LDM_IMM.
- RTI with defaults -> stall high 3 cycles. Pop #1: branch_type=110, sp_op=10. Pop #2: flag_restore=1. Then bubble, then DECODE.
- CALL with flush asserted in CALL_PUSH cycle -> mem_write=0 next cycle, state DECODE, stall=0.
- rst asserted in POP_FLAGS -> all outputs zero, alu=NOP next edge; following PUSH decodes normally (mem_write=1, sp_op=01).
